// File: rtl/instr_assembler_pkg.sv
// Shared constants for the MIPS instruction assembler: format codes, field widths,
// default IM base address, FSM states and the field-packing helper.
package instr_assembler_pkg;

    localparam int OPC_W  = 6;
    localparam int REG_W  = 5;
    localparam int IMM_W  = 16;
    localparam int IDX_W  = 26;
    localparam int WORD_W = 32;

    localparam logic [1:0] FMT_R   = 2'd0;
    localparam logic [1:0] FMT_I   = 2'd1;
    localparam logic [1:0] FMT_J   = 2'd2;
    localparam logic [1:0] FMT_BAD = 2'd3;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_3000;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FULL = 2'd2
    } state_e;

    // FMT_BAD yields zero; the caller never pushes it.
    function automatic logic [WORD_W-1:0] pack_instr(
        input logic [1:0]       fmt,
        input logic [OPC_W-1:0] opcode,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] shamt,
        input logic [OPC_W-1:0] funct,
        input logic [IMM_W-1:0] imm16,
        input logic [IDX_W-1:0] index26
    );
        logic [WORD_W-1:0] w;
        w = '0;
        case (fmt)
            FMT_R:   w = {opcode, rs, rt, rd, shamt, funct};
            FMT_I:   w = {opcode, rs, rt, imm16};
            FMT_J:   w = {opcode, index26};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_assembler_fifo.sv
// DEPTH x W circular FIFO: push/pop on the same edge, async reset, sync flush.
// Write-to-read latency 1 edge; pushes when full and pops when empty are ignored.
module instr_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 32,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_d = count_q + CW'(1);
            else if (!do_push && do_pop) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/instr_assembler.sv
// Packs R/I/J field groups into words, queues them, writes them to IM at BASE_ADDR+4n.
// Accept->im_we two edges; in_ready drops when the FIFO or the IM image is full, never drops a word.
module instr_assembler
    import instr_assembler_pkg::*;
#(
    parameter  int          DEPTH     = 4,
    parameter  logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter  int          IM_WORDS  = 1024,
    localparam int          WC_W      = $clog2(IM_WORDS) + 1,
    localparam int          FC_W      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       fmt,
    input  logic [OPC_W-1:0] opcode,
    input  logic [REG_W-1:0] rs,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] shamt,
    input  logic [OPC_W-1:0] funct,
    input  logic [IMM_W-1:0] imm16,
    input  logic [IDX_W-1:0] index26,
    input  logic             out_ready,
    output logic             im_we,
    output logic [31:0]      im_addr,
    output logic [31:0]      im_wdata,
    output logic [WC_W-1:0]  word_count,
    output logic             full,
    output logic             fmt_err
);

    state_e            state_q, state_d;
    logic [WC_W-1:0]   word_count_q, word_count_d;
    logic              im_we_q, im_we_d;
    logic [31:0]       im_addr_q, im_addr_d;
    logic [31:0]       im_wdata_q, im_wdata_d;
    logic              fmt_err_q, fmt_err_d;

    logic [FC_W-1:0]   fifo_count;
    logic              fifo_empty, fifo_full;
    logic [WORD_W-1:0] head_dat, packed_word;
    logic [WC_W:0]     pending;
    logic              accept, push, pop;

    assign packed_word = pack_instr(fmt, opcode, rs, rt, rd, shamt, funct, imm16, index26);

    // Words already written plus words queued: the IM limit is reserved at accept time.
    assign pending  = {1'b0, word_count_q} + (WC_W+1)'(fifo_count);
    assign in_ready = !clear && !fifo_full && (state_q != S_FULL)
                    && (pending < (WC_W+1)'(IM_WORDS));
    assign accept   = in_valid && in_ready;
    assign push     = accept && (fmt != FMT_BAD);
    assign pop      = !fifo_empty && out_ready && (state_q != S_FULL) && !clear;

    instr_fifo #(
        .DEPTH (DEPTH),
        .W     (WORD_W)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (clear),
        .push     (push),
        .push_dat (packed_word),
        .pop      (pop),
        .pop_dat  (head_dat),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        im_we_d      = 1'b0;
        im_addr_d    = im_addr_q;
        im_wdata_d   = im_wdata_q;
        fmt_err_d    = accept && (fmt == FMT_BAD);
        if (clear) begin
            word_count_d = '0;
            fmt_err_d    = 1'b0;
            state_d      = S_IDLE;
        end else begin
            if (pop) begin
                im_we_d      = 1'b1;
                im_wdata_d   = head_dat;
                im_addr_d    = BASE_ADDR + (32'(word_count_q) << 2);
                word_count_d = word_count_q + WC_W'(1);
            end
            case (state_q)
                S_IDLE: if (push) state_d = S_RUN;
                S_RUN:  if (pop && !push && (fifo_count == FC_W'(1))) state_d = S_IDLE;
                default: state_d = state_q;
            endcase
            if (word_count_d == WC_W'(IM_WORDS)) state_d = S_FULL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            word_count_q <= '0;
            im_we_q      <= 1'b0;
            im_addr_q    <= '0;
            im_wdata_q   <= '0;
            fmt_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            im_we_q      <= im_we_d;
            im_addr_q    <= im_addr_d;
            im_wdata_q   <= im_wdata_d;
            fmt_err_q    <= fmt_err_d;
        end
    end

    assign im_we      = im_we_q;
    assign im_addr    = im_addr_q;
    assign im_wdata   = im_wdata_q;
    assign word_count = word_count_q;
    assign fmt_err    = fmt_err_q;
    assign full       = (state_q == S_FULL);

endmodule

// File: tb/tb_instr_assembler.sv
// Directed bench for instr_assembler (IM_WORDS shrunk to 8 so the capacity limit is reachable).
module tb_instr_assembler;
    import instr_assembler_pkg::*;

    localparam int IMW = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  fmt = 2'd0;
    logic [5:0]  opcode = '0;
    logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
    logic [5:0]  funct = '0;
    logic [15:0] imm16 = '0;
    logic [25:0] index26 = '0;
    logic        out_ready = 1'b0;
    logic        im_we;
    logic [31:0] im_addr, im_wdata;
    logic [3:0]  word_count;
    logic        full, fmt_err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int err_pulses = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          acc_cyc[$];
    bit          seen8;

    instr_assembler #(
        .DEPTH     (4),
        .BASE_ADDR (32'h0000_3000),
        .IM_WORDS  (IMW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .fmt        (fmt),
        .opcode     (opcode),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .funct      (funct),
        .imm16      (imm16),
        .index26    (index26),
        .out_ready  (out_ready),
        .im_we      (im_we),
        .im_addr    (im_addr),
        .im_wdata   (im_wdata),
        .word_count (word_count),
        .full       (full),
        .fmt_err    (fmt_err)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after posedge, so values at negedge are what the next edge sees.
    always @(negedge clk) begin
        cyc++;
        if (im_we) begin
            wr_addr.push_back(im_addr);
            wr_data.push_back(im_wdata);
            wr_cyc.push_back(cyc);
        end
        if (in_valid && in_ready) begin
            acc_cnt++;
            acc_cyc.push_back(cyc);
        end
        if (fmt_err) err_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        acc_cyc.delete();
        acc_cnt = 0;
        err_pulses = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        clear_logs();
    endtask

    task automatic send(input logic [1:0] f, input logic [5:0] op, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                        input logic [5:0] fn, input logic [15:0] im, input logic [25:0] ix);
        int n;
        n = 0;
        fmt = f; opcode = op; rs = s; rt = t; rd = d; shamt = sh;
        funct = fn; imm16 = im; index26 = ix;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    initial begin
        do_reset();
        check("rst_im_we",    32'(im_we), 32'd0);
        check("rst_im_addr",  im_addr, 32'd0);
        check("rst_im_wdata", im_wdata, 32'd0);
        check("rst_wc",       32'(word_count), 32'd0);
        check("rst_full",     32'(full), 32'd0);
        check("rst_fmt_err",  32'(fmt_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // addu $3,$1,$2
        out_ready = 1'b1;
        send(FMT_R, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'h0, 26'h0);
        wait_cycles(3);
        check("r_writes", wr_addr.size(), 32'd1);
        if (wr_addr.size() >= 1 && acc_cyc.size() >= 1) begin
            check("r_addr", wr_addr[0], 32'h0000_3000);
            check("r_data", wr_data[0], 32'h0022_1821);
            check("r_latency", wr_cyc[0] - acc_cyc[0], 32'd2);
        end
        check("r_wc", 32'(word_count), 32'd1);

        // ori $1,$0,0x1234 then j 0xC03, back to back
        do_reset();
        out_ready = 1'b1;
        send(FMT_I, 6'h0d, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h1234, 26'h0);
        send(FMT_J, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h000_0C03);
        wait_cycles(4);
        check("ij_writes", wr_addr.size(), 32'd2);
        if (wr_addr.size() >= 2) begin
            check("ij_addr0", wr_addr[0], 32'h0000_3000);
            check("ij_data0", wr_data[0], 32'h3401_1234);
            check("ij_addr1", wr_addr[1], 32'h0000_3004);
            check("ij_data1", wr_data[1], 32'h0800_0C03);
            check("ij_consecutive", wr_cyc[1] - wr_cyc[0], 32'd1);
        end

        // Backpressure: six offers with IM side stalled
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            fmt = FMT_I; opcode = 6'h0d; rs = 5'd0; rt = 5'd1; imm16 = 16'(i);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("bp_accepts", acc_cnt, 32'd4);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_no_write", wr_addr.size(), 32'd0);
        out_ready = 1'b1;
        wait_cycles(6);
        check("bp_writes", wr_addr.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (wr_addr.size() > i) begin
                check($sformatf("bp_addr%0d", i), wr_addr[i], 32'h0000_3000 + 32'(4 * i));
                check($sformatf("bp_data%0d", i), wr_data[i], 32'h3401_0000 + 32'(i));
            end
        end
        check("bp_ready_again", 32'(in_ready), 32'd1);

        // Invalid format sandwiched between two valid words
        do_reset();
        out_ready = 1'b1;
        send(FMT_I, 6'h0d, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'hAAAA, 26'h0);
        send(FMT_BAD, 6'h3f, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3f, 16'hFFFF, 26'h3FF_FFFF);
        send(FMT_J, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h000_0155);
        wait_cycles(4);
        check("bad_err_pulses", err_pulses, 32'd1);
        check("bad_writes", wr_addr.size(), 32'd2);
        if (wr_addr.size() >= 2) begin
            check("bad_addr0", wr_addr[0], 32'h0000_3000);
            check("bad_data0", wr_data[0], 32'h3401_AAAA);
            check("bad_addr1", wr_addr[1], 32'h0000_3004);
            check("bad_data1", wr_data[1], 32'h0800_0155);
        end
        check("bad_wc", 32'(word_count), 32'd2);

        // Capacity: stream continuously, only IMW words fit
        do_reset();
        out_ready = 1'b1;
        fmt = FMT_I; opcode = 6'h0d; rs = 5'd0; rt = 5'd1;
        in_valid = 1'b1;
        seen8 = 1'b0;
        for (int c = 0; c < 20; c++) begin
            imm16 = 16'(acc_cnt);
            @(posedge clk);
            #1;
            if (acc_cnt == IMW && !seen8) begin
                seen8 = 1'b1;
                check("cap_ready_after_last", 32'(in_ready), 32'd0);
            end
        end
        in_valid = 1'b0;
        check("cap_accepts", acc_cnt, 32'(IMW));
        check("cap_writes", wr_addr.size(), 32'(IMW));
        if (wr_addr.size() == IMW) begin
            check("cap_last_addr", wr_addr[IMW-1], 32'h0000_301C);
            check("cap_last_data", wr_data[IMW-1], 32'h3401_0007);
        end
        check("cap_full", 32'(full), 32'd1);
        check("cap_wc", 32'(word_count), 32'(IMW));
        check("cap_in_ready", 32'(in_ready), 32'd0);

        // clear releases FULL, then clear mid-drain
        out_ready = 1'b0;
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        clear_logs();
        check("clr_full_exit", 32'(full), 32'd0);
        check("clr_wc_zero", 32'(word_count), 32'd0);
        for (int i = 0; i < 4; i++)
            send(FMT_I, 6'h0d, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'h0100 + 16'(i), 26'h0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        check("clr_we_low", 32'(im_we), 32'd0);
        wait_cycles(5);
        check("clr_writes", wr_addr.size(), 32'd1);
        check("clr_wc", 32'(word_count), 32'd0);
        check("clr_addr_hold", im_addr, 32'h0000_3000);
        send(FMT_J, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h0, 16'h0, 26'h000_03FF);
        wait_cycles(3);
        check("clr_next_writes", wr_addr.size(), 32'd2);
        if (wr_addr.size() >= 2) begin
            check("clr_next_addr", wr_addr[1], 32'h0000_3000);
            check("clr_next_data", wr_data[1], 32'h0800_03FF);
        end

        // Asynchronous reset in the middle of a drain
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++)
            send(FMT_I, 6'h0d, 5'd0, 5'd1, 5'd0, 5'd0, 6'h0, 16'(i), 26'h0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ar_pre_we", 32'(im_we), 32'd1);
        check("ar_pre_addr", im_addr, 32'h0000_3004);
        #2 reset = 1'b1;
        #1;
        check("ar_im_we", 32'(im_we), 32'd0);
        check("ar_im_addr", im_addr, 32'd0);
        check("ar_im_wdata", im_wdata, 32'd0);
        check("ar_wc", 32'(word_count), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        clear_logs();
        wait_cycles(5);
        check("ar_queue_lost", wr_addr.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_assembler.md
Name: instr_assembler

Overview:
- Inverse of the instruction field splitter: packs R/I/J-format MIPS field groups into 32-bit instruction words.
- Buffers the packed words in a small FIFO.
- Drains the FIFO into the instruction-memory write port at sequential word addresses starting at BASE_ADDR.
- Used as the loader that builds the IM image for the P4 CPU before and between test runs.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
BASE_ADDR, 32'h0000_3000, byte address of the first IM word written
IM_WORDS, 1024, IM capacity in words; hard write limit

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
clear  in  1  synchronous flush/restart
in_valid  in  1  field group valid
in_ready  out  1  block accepts field group this cycle
fmt  in  2  0=R, 1=I, 2=J, 3=invalid
opcode  in  6  Instr[31:26]
rs  in  5  R/I Instr[25:21]
rt  in  5  R/I Instr[20:16]
rd  in  5  R Instr[15:11]
shamt  in  5  R Instr[10:6]
funct  in  6  R Instr[5:0]
imm16  in  16  I Instr[15:0]
index26  in  26  J Instr[25:0]
out_ready  in  1  IM side accepts a write next edge
im_we  out  1  registered IM write strobe
im_addr  out  32  registered IM byte address
im_wdata  out  32  registered instruction word
word_count  out  11  words written since reset/clear (clog2(IM_WORDS)+1)
full  out  1  word_count == IM_WORDS
fmt_err  out  1  one-cycle pulse: invalid fmt accepted

Behaviour:
- Reset values (asynchronous): im_we=0, im_addr=0, im_wdata=0, word_count=0, full=0, fmt_err=0, FIFO empty, FSM=IDLE.
- Packing (combinational, on accept):
  - R: {opcode,rs,rt,rd,shamt,funct}
  - I: {opcode,rs,rt,imm16}
  - J: {opcode,index26}
  - Unused fields are ignored.
- Accept happens when in_valid && in_ready at the edge.
- in_ready = !clear && fifo_count<DEPTH && (word_count+fifo_count)<IM_WORDS. Computed from registered counts only; no credit for a same-cycle pop. No accepted word is ever dropped.
- fmt==3 accepted: word discarded (no FIFO push); fmt_err=1 the next cycle only. The handshake still completes.
- Pop condition, evaluated each edge: FIFO non-empty && out_ready && !full && !clear. On pop:
  - im_we<=1, im_wdata<=head, im_addr<=BASE_ADDR+4*word_count
  - word_count<=word_count+1
- Otherwise im_we<=0. im_addr and im_wdata hold their last values.
- Latency: accept at edge k -> FIFO at edge k -> earliest im_we=1 in the cycle after edge k+1. Throughput is 1 word/cycle sustained.
- Simultaneous push and pop: both occur; fifo_count unchanged; pointers wrap modulo DEPTH.
- FSM:
  - IDLE (FIFO empty, !full) -> RUN on push
  - RUN -> IDLE when the last entry pops with no push
  - RUN/IDLE -> FULL when word_count reaches IM_WORDS
  - FULL holds: in_ready=0, no pops
  - full=1 iff state==FULL
- clear (priority over push/pop): flush FIFO, word_count<=0, im_we<=0, fmt_err<=0, state<=IDLE. im_addr and im_wdata hold.
- reset mid-drain: everything returns to reset values immediately; queued words are lost.
- out_ready low: the FIFO fills to DEPTH, then in_ready=0; nothing is overwritten.

Decomposition:
- Shared package: FMT_R/FMT_I/FMT_J/FMT_BAD constants, field-width constants (OPC_W=6, REG_W=5, IMM_W=16, IDX_W=26), default BASE_ADDR.
- Sub-module instr_fifo: DEPTH x 32, push/pop/count/empty/full, async reset, sync flush.
- Packing mux and FSM stay in the top.

Test Plan:
- R pack: addu with rs=1, rt=2, rd=3, shamt=0, funct=6'h21, out_ready=1 -> im_we pulse with im_addr=0x3000, im_wdata=0x00221821, word_count=1.
- I and J back-to-back: ori (opcode=6'h0d, rs=0, rt=1, imm16=16'h1234), then j (opcode=2, index26=26'h0000C03) -> writes 0x34011234 @0x3000 and 0x08000C03 @0x3004 on consecutive cycles.
- Backpressure: out_ready=0 while 6 valid words are offered -> exactly 4 accepted, in_ready=0. Raise out_ready -> 4 writes in order, addresses 0x3000..0x300C.
- Invalid fmt: fmt=3 between two valid words -> fmt_err pulses once. Only 2 writes, at 0x3000 and 0x3004 (no gap).
- Capacity with IM_WORDS=8: stream 10 words -> 8 writes, last at 0x301C. full=1, in_ready=0 from the edge after the 8th accept. 2 words are refused, never accepted.
- clear and reset: clear mid-drain with 3 queued -> no further im_we, word_count=0. The next word writes @0x3000. Async reset asserted mid-cycle -> outputs zero before the next edge.
